tick_gen_multi: RTL and testbench
=================================

TICK_GEN_MULTI -- requirements
Module: tick_gen_multi

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50_000_000, meaning the input clock frequency in Hz (documentation and default-divisor use only).
REQ-002 The block SHALL have parameter N_CH, default 4, meaning the number of independent tick channels (1..16).
REQ-003 The block SHALL have parameter CNT_W, default 32, meaning the divisor and counter width in bits.
REQ-004 The block SHALL have parameter DEF_DIV, default CLK_HZ, meaning the divisor loaded into every channel at reset (1 Hz tick).
REQ-005 The block SHALL have port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 The block SHALL have port ch_en, input, N_CH bits: per-channel run enable, level-sensitive.
REQ-008 The block SHALL have port ch_oneshot, input, N_CH bits: per-channel mode, 0 = periodic, 1 = one-shot.
REQ-009 The block SHALL have port sync, input, 1 bit: a 1-cycle pulse that zeroes all channel counters (phase alignment).
REQ-010 The block SHALL have port cfg_valid, input, 1 bit: a divisor-write request.
REQ-011 The block SHALL have port cfg_ready, output, 1 bit: the write is accepted in a cycle where cfg_valid and cfg_ready are both high.
REQ-012 The block SHALL have port cfg_ch, input, clog2(N_CH) bits (minimum 1): the target channel of the write.
REQ-013 The block SHALL have port cfg_div, input, CNT_W bits: the new divisor value.
REQ-014 The block SHALL have port cfg_err, output, 1 bit: a 1-cycle pulse when an accepted write is rejected.
REQ-015 The block SHALL have port tick, output, N_CH bits: a registered 1-cycle enable pulse per channel.
REQ-016 The block SHALL have port done, output, N_CH bits: a sticky one-shot completion flag per channel.

Function
REQ-017 Each channel SHALL hold an active divisor DIV, a shadow divisor, a pending flag and a counter cnt, all CNT_W bits wide except the flag.
REQ-018 While ch_en[i]=1 and done[i]=0, cnt SHALL increment each cycle; when cnt==DIV-1, cnt SHALL wrap to 0 and tick[i] SHALL be 1 in the following cycle.
REQ-019 Ticks SHALL therefore occur exactly every DIV cycles, and the first tick SHALL be registered DIV cycles after ch_en rises; DIV=1 SHALL give tick=1 on every cycle.
REQ-020 When ch_en[i]=0, cnt SHALL hold at 0, tick[i] SHALL be 0, and done[i] SHALL clear.
REQ-021 In one-shot mode, the wrap SHALL set done[i]; while done[i]=1 the counter SHALL hold at 0 with no further ticks until ch_en[i] is deasserted.
REQ-022 cfg_ready SHALL be 1 whenever rst=0, so a write always completes in one cycle.
REQ-023 An accepted write with cfg_div==0 or cfg_ch>=N_CH SHALL be discarded and SHALL pulse cfg_err on the next cycle.
REQ-024 A valid write to a disabled channel SHALL update DIV immediately.
REQ-025 A valid write to an enabled channel SHALL load the shadow divisor and set pending; DIV SHALL take the shadow value at the next wrap, so no period is ever truncated or stretched.
REQ-026 A later write SHALL overwrite the pending shadow value (last write wins).
REQ-027 sync SHALL set every cnt to 0 on the next edge and suppress any tick that cycle; pending divisors SHALL be applied at that point.
REQ-028 When sync coincides with a wrap, sync SHALL win and no tick SHALL be generated.
REQ-029 A write coinciding with its channel's wrap SHALL go to the shadow and apply at the following wrap.
REQ-030 Lowering DIV with pending set SHALL never leave cnt>=DIV, because the new value is applied only at a wrap or sync (cnt=0).

Reset
REQ-031 On rst=1, asynchronously: all cnt=0, DIV=DEF_DIV, shadow=DEF_DIV, pending=0, tick=0, done=0, cfg_err=0 and cfg_ready=0.
REQ-032 Reset asserted mid-period SHALL discard the partial count; after release the first tick SHALL occur DEF_DIV cycles after ch_en is seen high.

Structure
REQ-033 Package tick_gen_pkg SHALL hold the mode encoding (periodic/oneshot) and the clog2-based channel-index width function.
REQ-034 Per-channel logic SHALL be a sub-module tick_chan, instantiated N_CH times via generate; tick_gen_multi SHALL hold only config decode, the error flag and sync fan-out.

Verification
REQ-035 N_CH=4, DEF_DIV=5, ch_en=4'b0001 periodic: tick[0] SHALL occur every 5 cycles, the first registered 5 cycles after enable, and other ticks SHALL stay 0.
REQ-036 ch0 running at DIV=5, write cfg_div=3 mid-period: the current period SHALL stay 5 cycles and subsequent periods SHALL be 3 cycles.
REQ-037 ch1 one-shot with DIV=4: exactly one tick SHALL occur, done[1]=1 SHALL hold, and dropping then re-raising ch_en[1] SHALL clear done[1] and give one more tick.
REQ-038 Write cfg_div=0 and write cfg_ch=5 (N_CH=4): each SHALL produce one cfg_err pulse with divisors unchanged.
REQ-039 Channels with DIV=6 and DIV=9 at arbitrary phase, then pulse sync: both counters SHALL be 0, and ticks SHALL follow 6 and 9 cycles later with no tick on the sync cycle.
REQ-040 Assert rst for 1 cycle mid-count with DIV=1 on ch2: tick SHALL drop immediately and resume every cycle from the first enabled cycle after release.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// -----------------------------------------------------------------------------
// tick_gen_pkg
// Shared definitions for the multi-channel tick generator.
//   mode_e   : per-channel run mode (periodic / one-shot)
//   ch_idx_w : width of a channel index for n channels (minimum 1 bit)
// -----------------------------------------------------------------------------
package tick_gen_pkg;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } mode_e;

    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_gen_multi_chan.sv
// -----------------------------------------------------------------------------
// tick_chan
// One tick channel: counter, active divisor, shadow divisor and pending flag.
// Ports:
//   clk, rst      : system clock, async active-high reset
//   i_en          : run enable (level)
//   i_mode        : periodic / one-shot
//   i_sync        : zero the counter this edge, suppress tick, apply pending
//   i_wr, i_div   : validated divisor write aimed at this channel
//   o_tick        : registered 1-cycle tick
//   o_done        : sticky one-shot completion flag
// -----------------------------------------------------------------------------
module tick_chan
    import tick_gen_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int DEF_DIV = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  mode_e            i_mode,
    input  logic             i_sync,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_div,
    output logic             o_tick,
    output logic             o_done
);

    localparam logic [CNT_W-1:0] L_DEF = CNT_W'(DEF_DIV);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_shadow;
    logic             r_pend;
    logic             r_tick;
    logic             r_done;

    logic w_run;
    logic w_wrap;
    logic w_apply;

    assign w_run  = i_en & ~r_done;
    // r_div is never 0 (zero writes are rejected upstream), so DIV-1 cannot underflow
    assign w_wrap = w_run & (r_cnt == (r_div - CNT_W'(1)));
    // Pending divisor only lands where cnt is (or becomes) 0: a wrap, a sync,
    // or while disabled. This keeps cnt < DIV and never truncates a period.
    assign w_apply = r_pend & (w_wrap | i_sync | ~i_en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_div    <= L_DEF;
            r_shadow <= L_DEF;
            r_pend   <= 1'b0;
            r_tick   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            if (!i_en || i_sync || r_done || w_wrap)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CNT_W'(1);

            // sync beats a coincident wrap: no tick, no one-shot completion
            r_tick <= w_wrap & ~i_sync;

            if (!i_en)
                r_done <= 1'b0;
            else if (w_wrap && !i_sync && i_mode == MODE_ONESHOT)
                r_done <= 1'b1;

            // A write on the wrap edge goes to the shadow and waits for the
            // following wrap; it also supersedes any older pending value.
            if (i_wr && !i_en) begin
                r_div  <= i_div;
                r_pend <= 1'b0;
            end else if (i_wr) begin
                r_shadow <= i_div;
                r_pend   <= 1'b1;
            end else if (w_apply) begin
                r_div  <= r_shadow;
                r_pend <= 1'b0;
            end
        end
    end

    assign o_tick = r_tick;
    assign o_done = r_done;

endmodule

// File: rtl/tick_gen_multi.sv
// -----------------------------------------------------------------------------
// tick_gen_multi
// N_CH independent programmable tick generators sharing one clock.
// Ports:
//   clk, rst          : system clock, async active-high reset
//   ch_en[N_CH]       : per-channel run enable
//   ch_oneshot[N_CH]  : per-channel mode (0 periodic, 1 one-shot)
//   sync              : 1-cycle pulse, zeroes every counter
//   cfg_valid/ready   : divisor write handshake (ready whenever out of reset)
//   cfg_ch, cfg_div   : write target channel and divisor
//   cfg_err           : 1-cycle pulse after a rejected write
//   tick[N_CH]        : registered 1-cycle tick per channel
//   done[N_CH]        : sticky one-shot completion per channel
// -----------------------------------------------------------------------------
module tick_gen_multi
    import tick_gen_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int N_CH    = 4,
    parameter int CNT_W   = 32,
    parameter int DEF_DIV = CLK_HZ
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_CH-1:0]             ch_en,
    input  logic [N_CH-1:0]             ch_oneshot,
    input  logic                        sync,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [ch_idx_w(N_CH)-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]            cfg_div,
    output logic                        cfg_err,
    output logic [N_CH-1:0]             tick,
    output logic [N_CH-1:0]             done
);

    localparam int CH_W = ch_idx_w(N_CH);

    logic            r_err;
    logic            w_acc;
    logic            w_bad;
    logic            w_bad_ch;
    logic [N_CH-1:0] w_wr;

    assign cfg_ready = ~rst;
    assign w_acc     = cfg_valid & cfg_ready;

    // An out-of-range index only exists when N_CH is not a power of two
    if ((1 << CH_W) > N_CH) begin : g_range
        assign w_bad_ch = (32'(cfg_ch) >= 32'(N_CH));
    end else begin : g_full
        assign w_bad_ch = 1'b0;
    end

    assign w_bad = (cfg_div == '0) | w_bad_ch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_err <= 1'b0;
        else     r_err <= w_acc & w_bad;
    end

    assign cfg_err = r_err;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign w_wr[i] = w_acc & ~w_bad & (cfg_ch == CH_W'(i));

        tick_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .i_en   (ch_en[i]),
            .i_mode (mode_e'(ch_oneshot[i])),
            .i_sync (sync),
            .i_wr   (w_wr[i]),
            .i_div  (cfg_div),
            .o_tick (tick[i]),
            .o_done (done[i])
        );
    end

endmodule

// File: tb/tb_tick_gen_multi.sv
module tb_tick_gen_multi;

    // Instance A: N_CH=4, DEF_DIV=5. Instance B: N_CH=3 (index 3 is out of
    // range), DEF_DIV=1 (every-cycle ticks survive reset).
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] en, os;
    logic       sync, cv;
    logic [1:0] cch;
    logic [7:0] cdiv;
    logic [3:0] tick, done;
    logic       rdy, err;

    logic [2:0] b_en, b_os, b_tick, b_done;
    logic       b_sync, b_cv, b_rdy, b_err;
    logic [1:0] b_cch;
    logic [7:0] b_cdiv;

    tick_gen_multi #(.CLK_HZ(5), .N_CH(4), .CNT_W(8), .DEF_DIV(5)) u_a (
        .clk(clk), .rst(rst), .ch_en(en), .ch_oneshot(os), .sync(sync),
        .cfg_valid(cv), .cfg_ready(rdy), .cfg_ch(cch), .cfg_div(cdiv),
        .cfg_err(err), .tick(tick), .done(done)
    );

    tick_gen_multi #(.CLK_HZ(1), .N_CH(3), .CNT_W(8), .DEF_DIV(1)) u_b (
        .clk(clk), .rst(rst), .ch_en(b_en), .ch_oneshot(b_os), .sync(b_sync),
        .cfg_valid(b_cv), .cfg_ready(b_rdy), .cfg_ch(b_cch), .cfg_div(b_cdiv),
        .cfg_err(b_err), .tick(b_tick), .done(b_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] tk;
        logic [3:0] dn;
        logic       er;
        logic [2:0] btk;
        logic [2:0] bdn;
        logic       ber;
    } exp_t;

    typedef struct {
        logic [3:0] en;
        logic       cv;
        logic [1:0] cch;
        logic [7:0] cdiv;
        logic [3:0] tk;
        logic       er;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(input logic [3:0] tk, input logic [3:0] dn, input logic er,
                                input logic [2:0] btk, input logic ber);
        exp_t e;
        e.tk = tk; e.dn = dn; e.er = er; e.btk = btk; e.bdn = 3'b000; e.ber = ber;
        return e;
    endfunction

    task automatic addv(input logic [3:0] en_, input logic cv_, input logic [1:0] ch_,
                        input logic [7:0] dv_, input logic [3:0] tk_, input logic er_);
        vec_t v;
        v.en = en_; v.cv = cv_; v.cch = ch_; v.cdiv = dv_; v.tk = tk_; v.er = er_;
        tbl.push_back(v);
    endtask

    // Inputs are set at the falling edge; one rising edge consumes them and the
    // outputs are compared at the next falling edge.
    task automatic step(input string nm, input exp_t e);
        exp_t x, act;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        x = sb.pop_front();
        act.tk = tick; act.dn = done; act.er = err;
        act.btk = b_tick; act.bdn = b_done; act.ber = b_err;
        checks++;
        if (act !== x) begin
            errors++;
            $display("FAIL %s @%0t tick=%b exp %b done=%b exp %b err=%b exp %b b_tick=%b exp %b b_done=%b exp %b b_err=%b exp %b",
                     nm, $time, act.tk, x.tk, act.dn, x.dn, act.er, x.er,
                     act.btk, x.btk, act.bdn, x.bdn, act.ber, x.ber);
        end
    endtask

    task automatic chk(input string nm, input logic [14:0] act, input logic [14:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b exp %b", nm, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en = '0; os = '0; sync = 1'b0; cv = 1'b0; cch = '0; cdiv = '0;
        b_en = '0; b_os = '0; b_sync = 1'b0; b_cv = 1'b0; b_cch = '0; b_cdiv = '0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        chk("reset_outputs", {tick, done, err, rdy, b_tick, b_err, b_rdy}, 15'd0);
        rst = 1'b0;
        #1 chk("ready_out_of_reset", {13'd0, rdy, b_rdy}, 15'b11);

        // ---------------- periodic DEF_DIV=5 on ch0 ----------------
        en = 4'b0001;
        for (int k = 1; k <= 15; k++)
            step($sformatf("periodic5_k%0d", k), mk((k % 5 == 0) ? 4'b0001 : 4'b0000, 4'b0, 1'b0, 3'b0, 1'b0));

        // ---------------- divisor change 5 -> 3 mid-period ----------------
        for (int k = 16; k <= 29; k++) begin
            cv = (k == 18); cch = 2'd0; cdiv = 8'd3;
            step($sformatf("retime_k%0d", k),
                 mk((k == 20 || (k > 20 && (k - 20) % 3 == 0)) ? 4'b0001 : 4'b0000, 4'b0, 1'b0, 3'b0, 1'b0));
        end
        cv = 1'b0; en = 4'b0000;
        step("disable_ch0", mk(4'b0, 4'b0, 1'b0, 3'b0, 1'b0));

        // ---------------- config table: rejects, direct writes, then run ----------------
        addv(4'b0000, 1'b1, 2'd1, 8'd4, 4'b0000, 1'b0); // ch1 <- 4 (disabled: immediate)
        addv(4'b0000, 1'b1, 2'd0, 8'd0, 4'b0000, 1'b1); // zero divisor rejected
        addv(4'b0000, 1'b0, 2'd0, 8'd0, 4'b0000, 1'b0);
        addv(4'b0000, 1'b1, 2'd2, 8'd1, 4'b0000, 1'b0); // ch2 <- 1
        addv(4'b0000, 1'b1, 2'd3, 8'd0, 4'b0000, 1'b1); // back-to-back rejects
        addv(4'b0000, 1'b1, 2'd3, 8'd0, 4'b0000, 1'b1);
        addv(4'b1001, 1'b0, 2'd0, 8'd0, 4'b0000, 1'b0); // ch0 DIV3, ch3 DIV5 unchanged
        addv(4'b1001, 1'b0, 2'd0, 8'd0, 4'b0000, 1'b0);
        addv(4'b1001, 1'b0, 2'd0, 8'd0, 4'b0001, 1'b0);
        addv(4'b1001, 1'b0, 2'd0, 8'd0, 4'b0000, 1'b0);
        addv(4'b1001, 1'b0, 2'd0, 8'd0, 4'b1000, 1'b0);
        addv(4'b1001, 1'b0, 2'd0, 8'd0, 4'b0001, 1'b0);
        addv(4'b0000, 1'b0, 2'd0, 8'd0, 4'b0000, 1'b0);
        foreach (tbl[i]) begin
            en = tbl[i].en; cv = tbl[i].cv; cch = tbl[i].cch; cdiv = tbl[i].cdiv;
            step($sformatf("cfg_table_%0d", i), mk(tbl[i].tk, 4'b0, tbl[i].er, 3'b0, 1'b0));
        end
        cv = 1'b0;

        // ---------------- one-shot ch1 DIV=4, twice ----------------
        os = 4'b0010;
        for (int r = 0; r < 2; r++) begin
            en = 4'b0010;
            for (int k = 1; k <= 7; k++)
                step($sformatf("oneshot_r%0d_k%0d", r, k),
                     mk((k == 4) ? 4'b0010 : 4'b0000, (k >= 4) ? 4'b0010 : 4'b0000, 1'b0, 3'b0, 1'b0));
            en = 4'b0000;
            step($sformatf("oneshot_drop_r%0d", r), mk(4'b0, 4'b0, 1'b0, 3'b0, 1'b0));
        end
        os = 4'b0000;

        // ---------------- sync: DIV6 on ch0, DIV9 on ch1 ----------------
        cv = 1'b1; cch = 2'd0; cdiv = 8'd6;
        step("wr_ch0_6", mk(4'b0, 4'b0, 1'b0, 3'b0, 1'b0));
        cch = 2'd1; cdiv = 8'd9;
        step("wr_ch1_9", mk(4'b0, 4'b0, 1'b0, 3'b0, 1'b0));
        cv = 1'b0; en = 4'b0011;
        for (int k = 1; k <= 11; k++)
            step($sformatf("pre_sync_k%0d", k), mk({2'b00, k == 9, k == 6}, 4'b0, 1'b0, 3'b0, 1'b0));
        sync = 1'b1;  // coincides with ch0's wrap: no tick
        step("sync_on_wrap", mk(4'b0, 4'b0, 1'b0, 3'b0, 1'b0));
        sync = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            cv = (k == 13); cch = 2'd1; cdiv = 8'd4;  // ch1 shadow <- 4
            step($sformatf("post_sync_k%0d", k),
                 mk({2'b00, k == 9, (k == 6 || k == 12)}, 4'b0, 1'b0, 3'b0, 1'b0));
        end
        cv = 1'b0; sync = 1'b1;  // pending ch1=4 applied here
        step("sync_apply", mk(4'b0, 4'b0, 1'b0, 3'b0, 1'b0));
        sync = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            cv = (k == 6); cch = 2'd0; cdiv = 8'd2;   // write on ch0's wrap edge
            step($sformatf("post_sync2_k%0d", k),
                 mk({2'b00, (k % 4 == 0), (k == 6 || k == 12 || k == 14 || k == 16)}, 4'b0, 1'b0, 3'b0, 1'b0));
        end
        cv = 1'b0;

        // ---------------- B rejects, then reset mid-count ----------------
        en = 4'b0001;  // ch0 now DIV2
        for (int k = 1; k <= 7; k++) begin
            b_cv   = (k <= 2);
            b_cch  = (k == 1) ? 2'd3 : 2'd0;
            b_cdiv = (k == 1) ? 8'd7 : 8'd0;
            b_en   = (k >= 4) ? 3'b111 : 3'b000;
            step($sformatf("b_reject_k%0d", k),
                 mk((k % 2 == 0) ? 4'b0001 : 4'b0000, 4'b0, 1'b0, (k >= 4) ? 3'b111 : 3'b000, (k <= 2)));
        end
        b_cv = 1'b0;
        rst = 1'b1;
        #1 chk("async_reset", {tick, done, err, rdy, b_tick, b_err, b_rdy}, 15'd0);
        @(posedge clk);
        @(negedge clk);
        chk("reset_held", {tick, done, err, rdy, b_tick, b_err, b_rdy}, 15'd0);
        rst = 1'b0;
        for (int k = 1; k <= 10; k++)
            step($sformatf("after_reset_k%0d", k),
                 mk((k % 5 == 0) ? 4'b0001 : 4'b0000, 4'b0, 1'b0, 3'b111, 1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
